z80_bus_ctrl: RTL and testbench

Parametrised bus and system controller for the Z80 mini computer. It sits between `fz80` and the memory/IO devices and replaces the fixed clock divider and fixed 8-cycle reset stretcher with configurable equivalents. It also adds address decoding into ROM, RAM and IO chip selects, read and write strobes, and a per-region wait-state generator that drives the CPU wait request.

---
 rtl/z80_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_z80_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// z80_bus_ctrl
//
// Bus and system controller for the Z80 mini computer. It sits between the
// CPU core and the memory/IO devices and provides:
//   - a registered cpu_clk divided down from CLK50M (50% duty),
//   - a reset stretcher holding cpu_rst for RST_CYCLES cpu_clk rises,
//   - combinational ROM/RAM/IO chip selects and read/write strobes,
//   - an optional per-region wait-state generator driving cpu_wait.
//
// Optional feature macro: Z80_BUS_WAIT_EN
//   defined   : wait FSM built, ROM_WAIT/RAM_WAIT/IO_WAIT active.
//   undefined : no FSM, cpu_wait tied low, wait parameters ignored.
//
// Ports:
//   CLK50M      in   system clock, the only clock in the block
//   n_RST       in   asynchronous active-low reset
//   cpu_mreq    in   memory request (active high)
//   cpu_ioreq   in   IO request (active high)
//   cpu_rd      in   read (active high)
//   cpu_wr      in   write (active high)
//   cpu_addr    in   16-bit CPU address
//   cpu_clk     out  divided CPU clock
//   cpu_rst     out  active-high CPU reset
//   cpu_wait    out  active-high wait request
//   rom_n_ce    out  ROM chip select (active low)
//   ram_n_ce    out  RAM chip select (active low)
//   io_n_ce     out  IO chip select (active low)
//   n_oe        out  read strobe (active low)
//   n_we        out  write strobe (active low)
// -----------------------------------------------------------------------------
module z80_bus_ctrl #(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 8,
    parameter int ROM_ABITS  = 12,
    parameter int ROM_WAIT   = 0,
    parameter int RAM_WAIT   = 0,
    parameter int IO_WAIT    = 1
) (
    input  logic        CLK50M,
    input  logic        n_RST,
    input  logic        cpu_mreq,
    input  logic        cpu_ioreq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    output logic        cpu_clk,
    output logic        cpu_rst,
    output logic        cpu_wait,
    output logic        rom_n_ce,
    output logic        ram_n_ce,
    output logic        io_n_ce,
    output logic        n_oe,
    output logic        n_we
);

    // Elaboration-time sanity check of the configuration.
    if (DIV < 2 || (DIV % 2) != 0 || RST_CYCLES < 1 || RST_CYCLES > 255 ||
        ROM_ABITS < 8 || ROM_ABITS > 15 ||
        ROM_WAIT < 0 || ROM_WAIT > 15 || RAM_WAIT < 0 || RAM_WAIT > 15 ||
        IO_WAIT < 0 || IO_WAIT > 15) begin : g_param_err
        $error("z80_bus_ctrl: parameter out of range");
    end

    // -------------------------------------------------------------------------
    // Clock divider
    // -------------------------------------------------------------------------
    localparam int HALF = DIV / 2;
    localparam int DCW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DCW-1:0] DIV_TC = DCW'(HALF - 1);

    logic [DCW-1:0] div_cnt_reg;
    logic           cpu_clk_reg;
    logic           div_tc;
    logic           clk_rise;

    assign div_tc   = (div_cnt_reg == DIV_TC);
    // High for the one CLK50M cycle whose closing edge drives cpu_clk 0->1.
    assign clk_rise = div_tc & ~cpu_clk_reg;

    always_ff @(posedge CLK50M or negedge n_RST) begin
        if (!n_RST) begin
            div_cnt_reg <= '0;
            cpu_clk_reg <= 1'b0;
        end else if (div_tc) begin
            div_cnt_reg <= '0;
            cpu_clk_reg <= ~cpu_clk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign cpu_clk = cpu_clk_reg;

    // -------------------------------------------------------------------------
    // Reset stretcher: saturating count of cpu_clk rises since n_RST release
    // -------------------------------------------------------------------------
    localparam logic [7:0] RST_TC = 8'(RST_CYCLES);

    logic [7:0] rst_cnt_reg;
    logic       rst_active;

    assign rst_active = (rst_cnt_reg != RST_TC);

    always_ff @(posedge CLK50M or negedge n_RST) begin
        if (!n_RST) begin
            rst_cnt_reg <= '0;
        end else if (clk_rise && rst_active) begin
            rst_cnt_reg <= rst_cnt_reg + 8'd1;
        end
    end

    assign cpu_rst = rst_active;

    // -------------------------------------------------------------------------
    // Address decode and strobes (combinational, blocked while in reset)
    // -------------------------------------------------------------------------
    localparam logic [16:0] ROM_TOP = 17'd1 << ROM_ABITS;

    logic in_rom;
    logic mem_cyc;
    logic io_cyc;
    logic bus_req;
    logic rom_sel;
    logic ram_sel;
    logic io_sel;
    logic oe_act;
    logic we_act;

    assign in_rom  = ({1'b0, cpu_addr} < ROM_TOP);
    // Simultaneous mreq and ioreq is illegal and selects nothing.
    assign mem_cyc = cpu_mreq & ~cpu_ioreq;
    assign io_cyc  = cpu_ioreq & ~cpu_mreq;
    assign bus_req = cpu_mreq | cpu_ioreq;

    assign rom_sel = ~rst_active & mem_cyc & in_rom;
    assign ram_sel = ~rst_active & mem_cyc & ~in_rom;
    assign io_sel  = ~rst_active & io_cyc;
    assign oe_act  = ~rst_active & cpu_rd & bus_req;
    assign we_act  = ~rst_active & cpu_wr & bus_req;

    assign rom_n_ce = ~rom_sel;
    assign ram_n_ce = ~ram_sel;
    assign io_n_ce  = ~io_sel;
    assign n_oe     = ~oe_act;
    assign n_we     = ~we_act;

`ifdef Z80_BUS_WAIT_EN
    // -------------------------------------------------------------------------
    // Wait-state FSM
    //   IDLE : waiting for a decoded read/write access on a cpu_clk rise
    //   WAIT : cpu_wait asserted, counting down remaining wait periods
    //   HOLD : wait done; stay here until the bus cycle ends so that only
    //          one wait sequence runs per bus cycle
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

    wait_state_t state_reg, state_next;
    logic [3:0]  wcnt_reg, wcnt_next;
    logic        wait_reg, wait_next;
    logic [3:0]  region_wait;
    logic        access_start;

    always_comb begin
        region_wait = 4'd0;
        if (rom_sel) begin
            region_wait = 4'(ROM_WAIT);
        end else if (ram_sel) begin
            region_wait = 4'(RAM_WAIT);
        end else if (io_sel) begin
            region_wait = 4'(IO_WAIT);
        end
    end

    assign access_start = clk_rise & (rom_sel | ram_sel | io_sel) & (cpu_rd | cpu_wr);

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        wait_next  = wait_reg;
        case (state_reg)
            ST_IDLE: begin
                if (access_start) begin
                    wcnt_next = region_wait;
                    if (region_wait == 4'd0) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_WAIT;
                        wait_next  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus_req) begin
                    // CPU abandoned the cycle: release immediately.
                    state_next = ST_IDLE;
                    wcnt_next  = 4'd0;
                    wait_next  = 1'b0;
                end else if (clk_rise) begin
                    // The rise that takes the count to zero ends the wait, so
                    // cpu_wait spans exactly region_wait cpu_clk periods.
                    if (wcnt_reg <= 4'd1) begin
                        state_next = ST_HOLD;
                        wcnt_next  = 4'd0;
                        wait_next  = 1'b0;
                    end else begin
                        wcnt_next = wcnt_reg - 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (clk_rise && !bus_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                wcnt_next  = 4'd0;
                wait_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK50M or negedge n_RST) begin
        if (!n_RST) begin
            state_reg <= ST_IDLE;
            wcnt_reg  <= 4'd0;
            wait_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            wait_reg  <= wait_next;
        end
    end

    assign cpu_wait = wait_reg & ~rst_active;
`else
    assign cpu_wait = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_ctrl
//
// Scoreboard bench for z80_bus_ctrl with DIV=4, RST_CYCLES=8, ROM_ABITS=12,
// ROM_WAIT=0, RAM_WAIT=3, IO_WAIT=1. Each bus transaction pushes its expected
// decode vector and cpu_wait length into a queue; a monitor samples the DUT
// during the transaction and pops/compares when the transaction ends.
// Expected wait lengths are zero when Z80_BUS_WAIT_EN is not defined.
// -----------------------------------------------------------------------------
module tb_z80_bus_ctrl;

    localparam int DIV        = 4;
    localparam int RST_CYCLES = 8;
    localparam int ROM_ABITS  = 12;
    localparam int ROM_WAIT   = 0;
    localparam int RAM_WAIT   = 3;
    localparam int IO_WAIT    = 1;
`ifdef Z80_BUS_WAIT_EN
    localparam int WAIT_EN = 1;
`else
    localparam int WAIT_EN = 0;
`endif
    // First rise after DIV/2 cycles, then one rise per DIV cycles.
    localparam int RST_FALL_CYC = DIV / 2 + (RST_CYCLES - 1) * DIV;

    logic        CLK50M = 1'b0;
    logic        n_RST;
    logic        cpu_mreq, cpu_ioreq, cpu_rd, cpu_wr;
    logic [15:0] cpu_addr;
    logic        cpu_clk, cpu_rst, cpu_wait;
    logic        rom_n_ce, ram_n_ce, io_n_ce, n_oe, n_we;

    z80_bus_ctrl #(
        .DIV        (DIV),
        .RST_CYCLES (RST_CYCLES),
        .ROM_ABITS  (ROM_ABITS),
        .ROM_WAIT   (ROM_WAIT),
        .RAM_WAIT   (RAM_WAIT),
        .IO_WAIT    (IO_WAIT)
    ) dut (
        .CLK50M    (CLK50M),
        .n_RST     (n_RST),
        .cpu_mreq  (cpu_mreq),
        .cpu_ioreq (cpu_ioreq),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .cpu_wait  (cpu_wait),
        .rom_n_ce  (rom_n_ce),
        .ram_n_ce  (ram_n_ce),
        .io_n_ce   (io_n_ce),
        .n_oe      (n_oe),
        .n_we      (n_we)
    );

    always #10 CLK50M = ~CLK50M;

    typedef struct {
        string      name;
        logic [4:0] dec;      // {rom_n_ce, ram_n_ce, io_n_ce, n_oe, n_we}
        int         wait_cyc; // CLK50M cycles with cpu_wait high
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic in_txn   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: capture decode on the first sample of a transaction, count
    // cpu_wait cycles throughout, compare against the queue at its end.
    bit         mon_was_in = 1'b0;
    int         mon_wcyc   = 0;
    logic [4:0] mon_dec    = '0;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge CLK50M);
            if (in_txn) begin
                if (!mon_was_in) begin
                    mon_wcyc = 0;
                    mon_dec  = {rom_n_ce, ram_n_ce, io_n_ce, n_oe, n_we};
                end
                if (cpu_wait) mon_wcyc++;
            end else if (mon_was_in) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: actual empty required entry");
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_decode"}, 32'(mon_dec), 32'(mon_e.dec));
                    check({mon_e.name, "_wait_cycles"}, 32'(mon_wcyc), 32'(mon_e.wait_cyc));
                    $display("txn %-10s decode=%b (req %b) wait_cycles=%0d (req %0d)",
                             mon_e.name, mon_dec, mon_e.dec, mon_wcyc, mon_e.wait_cyc);
                end
            end
            mon_was_in = in_txn;
        end
    end

    task automatic drive_bus(input logic mreq, input logic ioreq, input logic rd,
                             input logic wr, input logic [15:0] addr);
        cpu_mreq  = mreq;
        cpu_ioreq = ioreq;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
    endtask

    // One bus cycle held for 6 cpu_clk periods, then 3 idle periods.
    task automatic do_txn(input string name, input logic mreq, input logic ioreq,
                          input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [4:0] dec, input int wait_periods);
        exp_t e;
        e.name     = name;
        e.dec      = dec;
        e.wait_cyc = WAIT_EN * wait_periods * DIV;
        @(posedge CLK50M);
        #2;
        exp_q.push_back(e);
        drive_bus(mreq, ioreq, rd, wr, addr);
        in_txn = 1'b1;
        repeat (6 * DIV) @(posedge CLK50M);
        #2;
        drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        in_txn = 1'b0;
        repeat (3 * DIV) @(posedge CLK50M);
    endtask

    // Counts CLK50M rises after release until cpu_rst drops (bounded).
    task automatic measure_stretch(input string tag, output int fall_cyc,
                                   output int rises, output int first_rise,
                                   output int second_rise);
        logic prev_clk;
        prev_clk    = cpu_clk;
        fall_cyc    = -1;
        rises       = 0;
        first_rise  = -1;
        second_rise = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge CLK50M);
            #1;
            if (cpu_clk && !prev_clk) begin
                rises++;
                if (rises == 1) first_rise = k;
                if (rises == 2) second_rise = k;
            end
            prev_clk = cpu_clk;
            if (!cpu_rst) begin
                fall_cyc = k;
                break;
            end
        end
        if (fall_cyc < 0) $display("FAIL %s_timeout: actual no cpu_rst fall required fall within 200 cycles", tag);
    endtask

    int fall_cyc, rises, first_rise, second_rise;
`ifdef Z80_BUS_WAIT_EN
    bit wait_seen;
`endif

    initial begin
        n_RST = 1'b0;
        // Bus active during reset: decode must stay gated off.
        drive_bus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0123);
        repeat (3) @(posedge CLK50M);
        @(negedge CLK50M);
        check("reset_outputs",
              32'({cpu_clk, cpu_rst, cpu_wait, rom_n_ce, ram_n_ce, io_n_ce, n_oe, n_we}),
              32'(8'b0101_1111));

        // Release and measure the stretch.
        n_RST = 1'b1;
        measure_stretch("stretch", fall_cyc, rises, first_rise, second_rise);
        check("first_cpu_clk_rise", 32'(first_rise), 32'(DIV / 2));
        check("cpu_clk_period", 32'(second_rise - first_rise), 32'(DIV));
        check("rst_fall_rise_count", 32'(rises), 32'(RST_CYCLES));
        check("rst_fall_cycle", 32'(fall_cyc), 32'(RST_FALL_CYC));
        #1;
        check("rom_ce_after_rst", 32'(rom_n_ce), 32'd0);
        drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3 * DIV) @(posedge CLK50M);

        //     name        mreq  ioreq rd    wr    addr      decode    waits
        do_txn("rom_rd",   1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 5'b01101, ROM_WAIT);
        do_txn("io_wr",    1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 5'b11010, IO_WAIT);
        do_txn("ram_rd1",  1'b1, 1'b0, 1'b1, 1'b0, 16'h1000, 5'b10101, RAM_WAIT);
        do_txn("ram_rd2",  1'b1, 1'b0, 1'b1, 1'b0, 16'h1000, 5'b10101, RAM_WAIT);
        do_txn("rom_top",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0FFF, 5'b01110, ROM_WAIT);
        do_txn("ram_top",  1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 5'b10110, RAM_WAIT);
        do_txn("both_req", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0123, 5'b11101, 0);
        do_txn("mreq_only",1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 5'b10111, 0);
        do_txn("io_rd",    1'b0, 1'b1, 1'b1, 1'b0, 16'h0080, 5'b11001, IO_WAIT);

        // Asynchronous reset in the middle of a RAM wait sequence.
        @(posedge CLK50M);
        #2;
        drive_bus(1'b1, 1'b0, 1'b1, 1'b0, 16'h1000);
`ifdef Z80_BUS_WAIT_EN
        wait_seen = 1'b0;
        for (int k = 0; k < 20 * DIV; k++) begin
            @(posedge CLK50M);
            #1;
            if (cpu_wait) begin
                wait_seen = 1'b1;
                break;
            end
        end
        check("wait_before_reset", 32'(wait_seen), 32'd1);
        repeat (DIV) @(posedge CLK50M);
`else
        repeat (2 * DIV) @(posedge CLK50M);
`endif
        @(posedge CLK50M);
        #3;
        n_RST = 1'b0;
        #1;
        check("midwait_reset_outputs",
              32'({cpu_clk, cpu_rst, cpu_wait, rom_n_ce, ram_n_ce, io_n_ce, n_oe, n_we}),
              32'(8'b0101_1111));
        drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge CLK50M);
        @(negedge CLK50M);
        n_RST = 1'b1;
        measure_stretch("restretch", fall_cyc, rises, first_rise, second_rise);
        check("restretch_rise_count", 32'(rises), 32'(RST_CYCLES));
        check("restretch_fall_cycle", 32'(fall_cyc), 32'(RST_FALL_CYC));
        repeat (2 * DIV) @(posedge CLK50M);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual still running required finish by 2ms");
        $fatal(1, "simulation time limit");
    end

endmodule
